regfile_scoreboard: RTL

- Tracks outstanding writes to the 32-entry MIPS register file and gates instruction issue so no instruction reads a register with a write still in flight (RAW interlock).
- Sits between decode/issue and the register-file read stage.
- Writeback retires entries.
- Also provides a per-register busy mask and a saturating stall-cycle counter.

---
 rtl/regfile_scoreboard_pkg.sv | 16 +
 rtl/regfile_scoreboard_pend_counter.sv | 40 ++++
 rtl/regfile_scoreboard.sv | 96 +++++++++
 3 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// Shared register-index definitions for the register-file scoreboard.
package regfile_scoreboard_pkg;

  localparam int NUM_REGS = 32;

  typedef logic [4:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;
  localparam reg_idx_t REG_LINK = 5'd31;

  // r0 is hardwired to zero, so it never carries a hazard.
  function automatic logic is_tracked(input reg_idx_t r);
    return r != REG_ZERO;
  endfunction

endpackage

// File: rtl/regfile_scoreboard_pend_counter.sv
// Saturating up/down count of in-flight writes for one architectural register.
module sb_pend_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic [CNT_W-1:0] max,
  output logic [CNT_W-1:0] count,
  output logic             nonzero,
  output logic             full,
  output logic             underflow
);

  logic up;
  logic down;

  assign nonzero   = count != '0;
  assign full      = count == max;
  assign underflow = dec & ~nonzero;

  // A decrement landing in the same cycle makes room, so a full counter may
  // still take an increment; the pair then cancels.
  assign down = dec & nonzero;
  assign up   = inc & (~full | down);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case ({up, down})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// RAW interlock for the 32-entry register file: counts writes in flight per
// register and holds issue while a source or a saturated destination is busy.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int MAX_PEND = 3,
  parameter int CNT_W    = 3,
  parameter int STALL_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               issue_valid,
  output logic               issue_ready,
  input  reg_idx_t           issue_rs,
  input  reg_idx_t           issue_rt,
  input  logic               issue_use_rt,
  input  logic               issue_wr,
  input  logic               issue_link,
  input  reg_idx_t           issue_rd,
  input  logic               wb_valid,
  input  reg_idx_t           wb_addr,
  output logic [31:0]        busy_mask,
  output logic [STALL_W-1:0] stall_cnt,
  output logic               wb_err
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_PEND);

  logic                          writes;
  reg_idx_t                      dst;
  logic                          accept;
  logic                          haz_rs;
  logic                          haz_rt;
  logic                          haz_dst;
  logic [NUM_REGS-1:1]           inc;
  logic [NUM_REGS-1:1]           dec;
  logic [NUM_REGS-1:1]           nonzero;
  logic [NUM_REGS-1:1]           full;
  logic [NUM_REGS-1:1]           underflow;
  logic [NUM_REGS-1:0]           busy_all;
  logic [NUM_REGS-1:0]           full_all;
  logic [CNT_W*(NUM_REGS-1)-1:0] cnt_unused;

  assign writes = issue_wr | issue_link;
  assign dst    = issue_link ? REG_LINK : issue_rd;

  // Bit 0 is tied low so r0 reads as never busy and never full.
  assign busy_all  = {nonzero, 1'b0};
  assign full_all  = {full, 1'b0};
  assign busy_mask = busy_all;

  // No writeback bypass: a retire frees its register from the next cycle on.
  assign haz_rs  = is_tracked(issue_rs) & busy_all[issue_rs];
  assign haz_rt  = issue_use_rt & is_tracked(issue_rt) & busy_all[issue_rt];
  assign haz_dst = writes & is_tracked(dst) & full_all[dst];

  assign issue_ready = ~(haz_rs | haz_rt | haz_dst);
  assign accept      = issue_valid & issue_ready;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_pend
    assign inc[i] = accept & writes & (dst == reg_idx_t'(i));
    assign dec[i] = wb_valid & (wb_addr == reg_idx_t'(i));

    sb_pend_counter #(
      .CNT_W(CNT_W)
    ) u_pend (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       (inc[i]),
      .dec       (dec[i]),
      .max       (MAX_C),
      .count     (cnt_unused[(i-1)*CNT_W +: CNT_W]),
      .nonzero   (nonzero[i]),
      .full      (full[i]),
      .underflow (underflow[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (issue_valid && !issue_ready && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end

  // Underflow is only raised for r1..r31, so a writeback to r0 never flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_err <= 1'b0;
    end else if (|underflow) begin
      wb_err <= 1'b1;
    end
  end

endmodule
